// File: rtl/m_0_if.sv
// ============================================================================
// Module      : m_0_if
// Description : Data bus for the m_0 register: D into the storage, Q out.
//               The master drives D and observes Q; the register is the slave.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface m_0_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;

    // Producer of data, consumer of the registered value
    modport master (
        output D,
        input  Q
    );

    // The register itself: samples D, presents Q
    modport slave (
        input  D,
        output Q
    );
endinterface

`default_nettype wire

// File: rtl/m_0.sv
// ============================================================================
// Module      : m_0
// Description : WIDTH-bit D register with selectable active clock edge and an
//               asynchronous active-low reset that loads RST_VAL. Q comes
//               straight from the storage flops; there is no enable.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module m_0 #(
    parameter int               WIDTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit               CLK_POL = 1'b1
) (
    input  wire logic CLK,
    input  wire logic ARST,
    m_0_if.slave      bus
);

    // Storage flops; the only source of Q.
    logic [WIDTH-1:0] state;

    // The edge choice is static, so only one of the two flop banks exists.
    generate
        if (CLK_POL) begin : g_rise
            // Capture D on every rising edge; reset forces RST_VAL at once.
            always_ff @(posedge CLK or negedge ARST) begin
                if (!ARST) begin
                    state <= RST_VAL;
                end else begin
                    state <= bus.D;
                end
            end
        end else begin : g_fall
            // Capture D on every falling edge; reset forces RST_VAL at once.
            always_ff @(negedge CLK or negedge ARST) begin
                if (!ARST) begin
                    state <= RST_VAL;
                end else begin
                    state <= bus.D;
                end
            end
        end
    endgenerate

    assign bus.Q = state;

endmodule

`default_nettype wire

// File: tb/tb_m_0.sv
// ============================================================================
// Module      : tb_m_0
// Description : Directed bench for m_0. Instance a uses default parameters
//               (rising edge, reset to 0); instance b uses RST_VAL=2'b10 and
//               falling-edge capture. Expected values go into a queue as the
//               stimulus is applied and are popped at each observation point.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_m_0;

    logic clk;
    logic arst_a;
    logic arst_b;

    m_0_if #(.WIDTH(2)) if_a ();
    m_0_if #(.WIDTH(2)) if_b ();

    m_0 #(.WIDTH(2), .RST_VAL(2'b00), .CLK_POL(1'b1)) dut_a (
        .CLK  (clk),
        .ARST (arst_a),
        .bus  (if_a.slave)
    );

    m_0 #(.WIDTH(2), .RST_VAL(2'b10), .CLK_POL(1'b0)) dut_b (
        .CLK  (clk),
        .ARST (arst_b),
        .bus  (if_b.slave)
    );

    // 20 ns period, rising edges at 10 + 20k ns
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    typedef struct {
        string      tag;
        logic [1:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic push(input string tag, input logic [1:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [1:0] obs);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%b", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        arst_a = 1'b1;
        arst_b = 1'b1;
        if_a.D = 2'b00;
        if_b.D = 2'b00;

        // t=1: assert both resets between edges
        #1;
        arst_a = 1'b0;
        arst_b = 1'b0;
        #1;
        push("a_reset_state", 2'b00);  check(if_a.Q);
        push("b_reset_state", 2'b10);  check(if_b.Q);

        // Basic capture on the edge at t=10, then hold through a D change
        #3;
        arst_a = 1'b1;
        if_a.D = 2'b01;
        push("a_capture_01", 2'b01);
        @(posedge clk); #1;
        check(if_a.Q);
        #4 if_a.D = 2'b11;
        #4;
        push("a_hold_01", 2'b01);      check(if_a.Q);

        // Capture 11, then short reset pulse between edges
        push("a_capture_11", 2'b11);
        @(posedge clk); #1;
        check(if_a.Q);
        #7 arst_a = 1'b0;
        #2;
        push("a_pulse_clears", 2'b00); check(if_a.Q);
        #3 arst_a = 1'b1;
        #2;
        push("a_no_restore", 2'b00);   check(if_a.Q);
        #1 if_a.D = 2'b10;
        push("a_reload_10", 2'b10);
        @(posedge clk); #1;
        check(if_a.Q);

        // Reset held across three rising edges with D toggling
        #4 arst_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if_a.D = (i % 2 == 0) ? 2'b10 : 2'b01;
            push("a_reset_held", 2'b00);
            @(posedge clk); #1;
            check(if_a.Q);
            #4;
        end
        arst_a = 1'b1;
        #1;
        push("a_release_hold", 2'b00); check(if_a.Q);

        // Sweep D; mid-cycle changes must not reach Q, even across the falling edge
        for (int v = 0; v < 4; v++) begin
            logic [1:0] dv;
            dv = v[1:0];
            if_a.D = dv;
            push("a_sweep_edge", dv);
            @(posedge clk); #1;
            check(if_a.Q);
            #3 if_a.D = ~dv;
            #8;
            push("a_sweep_mid", dv);
            check(if_a.Q);
        end

        // Reset asserted coincident with a rising edge while D=10
        #3 if_a.D = 2'b10;
        @(posedge clk);
        arst_a = 1'b0;
        #1;
        push("a_reset_wins", 2'b00);   check(if_a.Q);
        #3 arst_a = 1'b1;

        // Instance b: reset held across a rising edge, then falling-edge capture
        @(posedge clk); #2;
        push("b_reset_over_edge", 2'b10); check(if_b.Q);
        arst_b = 1'b1;
        if_b.D = 2'b01;
        #3;
        push("b_release_hold", 2'b10);    check(if_b.Q);
        push("b_fall_capture_01", 2'b01);
        @(negedge clk); #1;
        check(if_b.Q);
        #1 if_b.D = 2'b11;
        push("b_rise_ignored", 2'b01);
        @(posedge clk); #1;
        check(if_b.Q);
        push("b_fall_capture_11", 2'b11);
        @(negedge clk); #1;
        check(if_b.Q);
        #3 arst_b = 1'b0;
        #1;
        push("b_pulse_clears", 2'b10);    check(if_b.Q);
        #1 arst_b = 1'b1;

        if (exp_q.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/m_0.md
M_0 -- requirements
Module: m_0

Interface
REQ-001 Parameter WIDTH, default 2: bit width of D and Q; SHALL be legal for any value >= 1.
REQ-002 Parameter RST_VAL, default all-zeros (WIDTH bits): value loaded into Q while reset is asserted.
REQ-003 Parameter CLK_POL, default 1: active clock edge (1 = rising, 0 = falling).
REQ-004 CLK  input  1  single clock; Q SHALL update only on the active edge selected by CLK_POL, except during reset.
REQ-005 ARST  input  1  reset; SHALL be asynchronous and active-low (asserted at 0).
REQ-006 D  input  WIDTH  data to be captured.
REQ-007 Q  output  WIDTH  registered data; SHALL be driven directly from the storage flops, with no combinational path from D.

Function
REQ-008 With ARST=1, each active CLK edge SHALL load Q with the value of D sampled at that edge; latency 1 edge.
REQ-009 Between active edges, Q SHALL hold its value regardless of changes on D.
REQ-010 Inactive CLK edges SHALL NOT change Q.
REQ-011 All WIDTH bits SHALL be captured together on the same edge; per-bit behaviour SHALL be identical.
REQ-012 D SHALL be copied to Q unchanged: no arithmetic, inversion, or width conversion.
REQ-013 There SHALL be no enable; every active edge without reset captures D.
REQ-014 Before the first reset or first active edge, Q is undefined; the design SHALL NOT rely on an initial value.

Reset
REQ-015 A falling edge on ARST SHALL force Q to RST_VAL immediately, with no dependence on CLK.
REQ-016 While ARST=0, Q SHALL remain RST_VAL, and active CLK edges and changes on D SHALL be ignored.
REQ-017 Reset SHALL have priority over capture: if ARST=0 at an active CLK edge, Q SHALL be RST_VAL.
REQ-018 After ARST rises to 1, Q SHALL hold RST_VAL until the next active CLK edge, then resume REQ-008 behaviour.
REQ-019 A reset pulse shorter than one clock period, placed between edges, SHALL still clear Q.
REQ-020 Reset between edges SHALL discard a previously captured value; Q SHALL NOT restore that value when ARST deasserts.

Verification (default parameters, 20 ns clock period, rising edge at t=10+20k ns)
REQ-021 Hold ARST=1 and drive D=2'b01 before the edge at t=10.
 -> Q=2'b01 after that edge, held until the next edge.
REQ-022 Capture D=2'b11, then pulse ARST=0 for 5 ns midway between edges.
 -> Q=2'b00 within the pulse and before any clock edge; Q stays 2'b00 after ARST=1 until the next edge.
 -> On that next edge, Q reloads the current D.
REQ-023 Hold ARST=0 across three rising edges with D toggling 2'b10/2'b01.
 -> Q=2'b00 throughout.
REQ-024 Sweep D through 2'b00, 2'b01, 2'b10, 2'b11 with ARST=1, changing D between edges.
 -> Q follows D one edge later.
 -> Mid-cycle D changes never appear on Q before the next edge.
REQ-025 Assert ARST=0 coincident with a rising edge while D=2'b10.
 -> Q=2'b00; reset wins.
REQ-026 Set RST_VAL=2'b10 and CLK_POL=0, then pulse reset and clock.
 -> Q=2'b10 during reset.
 -> Capture occurs on falling edges only.
